// File: rtl/pid_pkg.sv
// Shared types and width helpers for the time-multiplexed PID controller.
// Pure declarations: no latency; no flow control.
package pid_pkg;

    typedef enum logic [2:0] {IDLE, ERR, P, I, D, SUM, DONE} state_t;

    function automatic int err_w(input int dw);
        return dw + 1;
    endfunction

    function automatic int diff_w(input int dw);
        return dw + 2;
    endfunction

    function automatic int mul_w(input int dw, input int iw);
        return (dw + 2 > iw) ? dw + 2 : iw;
    endfunction

    function automatic int acc_w(input int dw, input int gw, input int iw);
        return mul_w(dw, iw) + gw + 2;
    endfunction

endpackage

// File: rtl/pid_clamp.sv
// Signed saturating clamp to [LO, HI], result truncated to OWD bits.
// Combinational, zero latency; no flow control.
module pid_clamp #(
    parameter int                    W   = 17,
    parameter int                    OWD = 16,
    parameter logic signed [W-1:0]   LO  = '0,
    parameter logic signed [W-1:0]   HI  = '0
) (
    input  logic signed [W-1:0] i_val,
    output logic [OWD-1:0]      o_val,
    output logic                o_flag
);

    always_comb begin
        o_val  = i_val[OWD-1:0];
        o_flag = 1'b0;
        if (i_val < LO) begin
            o_val  = LO[OWD-1:0];
            o_flag = 1'b1;
        end else if (i_val > HI) begin
            o_val  = HI[OWD-1:0];
            o_flag = 1'b1;
        end
    end

endmodule

// File: rtl/pid_multi.sv
// CH-channel PID sharing one signed multiplier, 5 cycles per channel.
// done 5*CH+1 cycles after start; no backpressure, start ignored while busy.
module pid_multi
    import pid_pkg::*;
#(
    parameter int CH      = 4,
    parameter int DW      = 16,
    parameter int GW      = 16,
    parameter int FRAC    = 8,
    parameter int IW      = 24,
    parameter int I_LIM   = 65535,
    parameter int OW      = 16,
    parameter int OUT_MIN = 256,
    parameter int OUT_MAX = 65535
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               clear_int,
    input  logic [CH*DW-1:0]   target,
    input  logic [CH*DW-1:0]   measured,
    input  logic [GW-1:0]      kp,
    input  logic [GW-1:0]      ki,
    input  logic [GW-1:0]      kd,
    output logic               busy,
    output logic               done,
    output logic [CH*OW-1:0]   pid_out,
    output logic [CH-1:0]      sat
);

    localparam int EW  = err_w(DW);
    localparam int DFW = diff_w(DW);
    localparam int MW  = mul_w(DW, IW);
    localparam int AW  = acc_w(DW, GW, IW);
    localparam int PW  = GW + 1 + MW;
    localparam int SW  = ((IW > EW) ? IW : EW) + 1;
    localparam int CW  = (CH > 1) ? $clog2(CH) : 1;
    localparam logic [OW-1:0] OMAX = OW'(OUT_MAX);
    localparam logic [OW-1:0] OMIN = OW'(OUT_MIN);
    localparam logic [CW-1:0] LAST = CW'(CH - 1);

    state_t                r_state;
    logic [CW-1:0]         r_ch;
    logic [CH*DW-1:0]      r_tgt, r_meas;
    logic [GW-1:0]         r_kp, r_ki, r_kd;
    logic signed [EW-1:0]  r_e;
    logic signed [IW-1:0]  r_inew;
    logic signed [AW-1:0]  r_acc;
    logic signed [IW-1:0]  r_integ [CH];
    logic signed [EW-1:0]  r_prev  [CH];
    logic [OW-1:0]         r_out   [CH];
    logic [OW-1:0]         r_sh_out[CH];
    logic [CH-1:0]         r_sat, r_sh_sat;
    logic                  r_busy, r_done, r_clr_pend;

    logic signed [DW-1:0]  w_tgt [CH];
    logic signed [DW-1:0]  w_meas[CH];
    logic signed [EW-1:0]  w_e;
    logic signed [SW-1:0]  w_isum;
    logic signed [IW-1:0]  w_iclamp, w_inext;
    logic                  w_iflag, w_hold;
    logic signed [DFW-1:0] w_diff;
    logic signed [GW:0]    w_a;
    logic signed [MW-1:0]  w_b;
    logic signed [PW-1:0]  w_prod;
    logic signed [AW-1:0]  w_s;
    logic [OW-1:0]         w_out;
    logic                  w_osat;

    for (genvar c = 0; c < CH; c++) begin : g_pack
        assign w_tgt[c]              = r_tgt[c*DW +: DW];
        assign w_meas[c]             = r_meas[c*DW +: DW];
        assign pid_out[c*OW +: OW]   = r_out[c];
    end

    assign w_e    = EW'(w_tgt[r_ch]) - EW'(w_meas[r_ch]);
    assign w_isum = SW'(r_integ[r_ch]) + SW'(r_e);
    assign w_diff = DFW'(r_e) - DFW'(r_prev[r_ch]);

    pid_clamp #(.W(SW), .OWD(IW), .LO(SW'(-I_LIM)), .HI(SW'(I_LIM))) u_iclamp (
        .i_val  (w_isum),
        .o_val  (w_iclamp),
        .o_flag (w_iflag)
    );
    assign w_inext = w_iflag ? w_iclamp : w_isum[IW-1:0];

    // Conditional integration: don't wind further into a limit we already hit.
    assign w_hold = r_sat[r_ch] &&
                    ((r_out[r_ch] == OMAX && !r_e[EW-1] && r_e != '0) ||
                     (r_out[r_ch] == OMIN &&  r_e[EW-1]));

    always_comb begin
        w_a = '0;
        w_b = '0;
        case (r_state)
            P:       begin w_a = {1'b0, r_kp}; w_b = MW'(r_e);    end
            I:       begin w_a = {1'b0, r_ki}; w_b = MW'(r_inew); end
            D:       begin w_a = {1'b0, r_kd}; w_b = MW'(w_diff); end
            default: ;
        endcase
    end
    assign w_prod = PW'(w_a) * PW'(w_b);

    assign w_s = r_acc >>> FRAC;
    pid_clamp #(.W(AW), .OWD(OW), .LO(AW'(OUT_MIN)), .HI(AW'(OUT_MAX))) u_oclamp (
        .i_val  (w_s),
        .o_val  (w_out),
        .o_flag (w_osat)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_ch       <= '0;
            r_tgt      <= '0;
            r_meas     <= '0;
            r_kp       <= '0;
            r_ki       <= '0;
            r_kd       <= '0;
            r_e        <= '0;
            r_inew     <= '0;
            r_acc      <= '0;
            r_sat      <= '0;
            r_sh_sat   <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_clr_pend <= 1'b0;
            for (int c = 0; c < CH; c++) begin
                r_integ[c]  <= '0;
                r_prev[c]   <= '0;
                r_out[c]    <= OMIN;
                r_sh_out[c] <= OMIN;
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (clear_int) begin
                        for (int c = 0; c < CH; c++) begin
                            r_integ[c] <= '0;
                            r_prev[c]  <= '0;
                        end
                    end
                    if (start) begin
                        r_tgt   <= target;
                        r_meas  <= measured;
                        r_kp    <= kp;
                        r_ki    <= ki;
                        r_kd    <= kd;
                        r_ch    <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ERR;
                    end
                end
                ERR: begin
                    r_e     <= w_e;
                    r_state <= P;
                end
                P: begin
                    r_acc   <= AW'(w_prod);
                    r_inew  <= w_hold ? r_integ[r_ch] : w_inext;
                    r_state <= I;
                end
                I: begin
                    r_acc         <= r_acc + AW'(w_prod);
                    r_integ[r_ch] <= r_inew;
                    r_state       <= D;
                end
                D: begin
                    r_acc   <= r_acc + AW'(w_prod);
                    r_state <= SUM;
                end
                SUM: begin
                    r_sh_out[r_ch] <= w_out;
                    r_sh_sat[r_ch] <= w_osat;
                    r_prev[r_ch]   <= r_e;
                    if (r_ch == LAST) begin
                        r_state <= DONE;
                    end else begin
                        r_ch    <= r_ch + CW'(1);
                        r_state <= ERR;
                    end
                end
                DONE: begin
                    for (int c = 0; c < CH; c++) r_out[c] <= r_sh_out[c];
                    r_sat  <= r_sh_sat;
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                    if (r_clr_pend || clear_int) begin
                        for (int c = 0; c < CH; c++) begin
                            r_integ[c] <= '0;
                            r_prev[c]  <= '0;
                        end
                    end
                    r_clr_pend <= 1'b0;
                    r_state    <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
            if (clear_int && r_state != IDLE && r_state != DONE)
                r_clr_pend <= 1'b1;
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sat  = r_sat;

endmodule

// File: tb/tb_pid_multi.sv
// Directed bench for pid_multi: three parameterisations share one stimulus bus.
module tb_pid_multi;

    localparam int CH = 4;
    localparam int DW = 16;
    localparam int OW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset, start, clear_int;
    logic [CH*DW-1:0] target, measured;
    logic [15:0]      kp, ki, kd;
    logic             busy_a, done_a, busy_b, done_b, busy_c, done_c;
    logic [CH*OW-1:0] out_a, out_b, out_c;
    logic [CH-1:0]    sat_a, sat_b, sat_c;

    pid_multi dut_a (
        .clk(clk), .reset(reset), .start(start), .clear_int(clear_int),
        .target(target), .measured(measured), .kp(kp), .ki(ki), .kd(kd),
        .busy(busy_a), .done(done_a), .pid_out(out_a), .sat(sat_a));

    pid_multi #(.OUT_MIN(0)) dut_b (
        .clk(clk), .reset(reset), .start(start), .clear_int(clear_int),
        .target(target), .measured(measured), .kp(kp), .ki(ki), .kd(kd),
        .busy(busy_b), .done(done_b), .pid_out(out_b), .sat(sat_b));

    pid_multi #(.OUT_MIN(0), .OUT_MAX(800), .I_LIM(1000)) dut_c (
        .clk(clk), .reset(reset), .start(start), .clear_int(clear_int),
        .target(target), .measured(measured), .kp(kp), .ki(ki), .kd(kd),
        .busy(busy_c), .done(done_c), .pid_out(out_c), .sat(sat_c));

    typedef struct {
        int         sel;
        logic       clr;
        int         tgt0;
        int         meas0;
        int         kp;
        int         ki;
        int         kd;
        int         out0;
        int         rest;
        logic [3:0] sat;
        int         integ;
    } vec_t;

    vec_t tv [11];
    int   nchk = 0;
    int   nerr = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: actual %0d required %0d", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] pack(input int o0, input int rest);
        return {16'(rest), 16'(rest), 16'(rest), 16'(o0)};
    endfunction

    task automatic set_in(input int t0, input int m0, input int p, input int i, input int d);
        target         = '0;
        measured       = '0;
        target[15:0]   = 16'(t0);
        measured[15:0] = 16'(m0);
        kp = 16'(p);
        ki = 16'(i);
        kd = 16'(d);
    endtask

    // Start one frame, watch 40 cycles; optionally re-pulse start+clear_int at cycle inj.
    task automatic run_frame(input logic clr, input int inj, output int lat, output int nd);
        lat = -1;
        nd  = 0;
        @(negedge clk);
        start     = 1'b1;
        clear_int = clr;
        @(negedge clk);
        start     = 1'b0;
        clear_int = 1'b0;
        chk("busy_after_start", longint'(busy_a), 1);
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (done_a) begin
                nd++;
                if (lat < 0) begin
                    lat = n;
                    chk("busy_at_done", longint'(busy_a), 0);
                end
            end
            start     = 1'b0;
            clear_int = 1'b0;
            if (n == inj) begin
                start     = 1'b1;
                clear_int = 1'b1;
            end
        end
    endtask

    initial begin
        int         lat, nd;
        logic [63:0] aout;
        logic [3:0]  asat;
        longint      aint;

        tv[0]  = '{0, 1'b1, 1000, 600, 256, 0,   0,   400, 256, 4'b1110, 400};
        tv[1]  = '{1, 1'b1, 100,  0,   0,   128, 0,   50,  0,   4'b0000, 100};
        tv[2]  = '{1, 1'b0, 100,  0,   0,   128, 0,   100, 0,   4'b0000, 200};
        tv[3]  = '{1, 1'b0, 100,  0,   0,   128, 0,   150, 0,   4'b0000, 300};
        tv[4]  = '{2, 1'b1, 600,  0,   0,   256, 0,   600, 0,   4'b0000, 600};
        tv[5]  = '{2, 1'b0, 600,  0,   0,   256, 0,   800, 0,   4'b0001, 1000};
        tv[6]  = '{2, 1'b0, 600,  0,   0,   256, 0,   800, 0,   4'b0001, 1000};
        tv[7]  = '{1, 1'b1, 0,    0,   0,   0,   256, 0,   0,   4'b0000, 0};
        tv[8]  = '{1, 1'b0, 300,  0,   0,   0,   256, 300, 0,   4'b0000, 300};
        tv[9]  = '{1, 1'b0, 300,  0,   0,   0,   256, 0,   0,   4'b0000, 600};
        tv[10] = '{0, 1'b1, 1000, 600, 256, 0,   0,   400, 256, 4'b1110, 400};

        reset     = 1'b1;
        start     = 1'b0;
        clear_int = 1'b0;
        set_in(0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", longint'(busy_a), 0);
        chk("rst_done", longint'(done_a), 0);
        chk("rst_out_a", longint'(out_a), longint'(pack(256, 256)));
        chk("rst_sat_a", longint'(sat_a), 0);
        chk("rst_out_b", longint'(out_b), longint'(pack(0, 0)));

        for (int i = 0; i < 11; i++) begin
            set_in(tv[i].tgt0, tv[i].meas0, tv[i].kp, tv[i].ki, tv[i].kd);
            run_frame(tv[i].clr, 0, lat, nd);
            case (tv[i].sel)
                0:       begin aout = out_a; asat = sat_a; aint = longint'(dut_a.r_integ[0]); end
                1:       begin aout = out_b; asat = sat_b; aint = longint'(dut_b.r_integ[0]); end
                default: begin aout = out_c; asat = sat_c; aint = longint'(dut_c.r_integ[0]); end
            endcase
            chk($sformatf("v%0d_latency", i), longint'(lat), 21);
            chk($sformatf("v%0d_ndone", i), longint'(nd), 1);
            chk($sformatf("v%0d_out", i), longint'(aout), longint'(pack(tv[i].out0, tv[i].rest)));
            chk($sformatf("v%0d_sat", i), longint'(asat), longint'(tv[i].sat));
            chk($sformatf("v%0d_integ", i), aint, longint'(tv[i].integ));
        end

        // Mid-frame start and clear_int: start ignored, clear deferred to frame end.
        set_in(100, 0, 0, 128, 0);
        run_frame(1'b1, 0, lat, nd);
        chk("seq_f1_out0", longint'(out_b[15:0]), 50);
        run_frame(1'b0, 5, lat, nd);
        chk("seq_f2_ndone", longint'(nd), 1);
        chk("seq_f2_latency", longint'(lat), 21);
        chk("seq_f2_out0", longint'(out_b[15:0]), 100);
        chk("seq_f2_integ", longint'(dut_b.r_integ[0]), 0);
        run_frame(1'b0, 0, lat, nd);
        chk("seq_f3_out0", longint'(out_b[15:0]), 50);

        // Reset at cycle 10 of a frame.
        set_in(1000, 600, 256, 0, 0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_busy", longint'(busy_a), 0);
        chk("midrst_done", longint'(done_a), 0);
        chk("midrst_out_a", longint'(out_a), longint'(pack(256, 256)));
        chk("midrst_sat_a", longint'(sat_a), 0);
        chk("midrst_out_c", longint'(out_c), longint'(pack(0, 0)));
        reset = 1'b0;
        nd = 0;
        repeat (30) begin
            @(negedge clk);
            if (done_a) nd++;
        end
        chk("midrst_no_done", longint'(nd), 0);
        run_frame(1'b0, 0, lat, nd);
        chk("postrst_latency", longint'(lat), 21);
        chk("postrst_out_a", longint'(out_a), longint'(pack(400, 256)));
        chk("postrst_sat_a", longint'(sat_a), 4'b1110);

        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/pid_multi.md
Name: pid_multi

Overview:
- Time-multiplexed, parametrised multi-channel PID controller; one shared signed multiplier; computes CH independent loops per frame.
- Sits between the attitude/MPU data path and the per-motor bb_pwm instances; pid_out slices feed speed_in, done drives speed_oe.
- Adds over the single-channel PID: channel count, configurable widths/fixed-point, integrator clamp with conditional-integration anti-windup, output saturation flags.

Parameters:
- CH, 4, number of channels.
- DW, 16, signed width of target/measured samples.
- GW, 16, unsigned gain width; gains are fixed point with FRAC fraction bits.
- FRAC, 8, fraction bits of gains; result is arithmetic-shifted right by FRAC (floor).
- IW, 24, signed integrator width.
- I_LIM, 65535, integrator magnitude limit, symmetric ±I_LIM, must be < 2^(IW-1).
- OW, 16, unsigned output width.
- OUT_MIN, 256, output lower clamp.
- OUT_MAX, 65535, output upper clamp.

Ports:
- clk  in  1  system clock.
- reset  in  1  reset, asynchronous, active-high.
- start  in  1  frame request pulse.
- clear_int  in  1  zero all integrators and previous errors.
- target  in  CH*DW  signed setpoints; channel c at bits [c*DW +: DW].
- measured  in  CH*DW  signed measurements, same packing.
- kp  in  GW  proportional gain, shared by all channels.
- ki  in  GW  integral gain, shared.
- kd  in  GW  derivative gain, shared.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse; pid_out valid from this cycle.
- pid_out  out  CH*OW  unsigned clamped outputs, same packing.
- sat  out  CH  per-channel flag: last output was clamped.

Behaviour:
- Reset values: busy=0, done=0, every pid_out slice=OUT_MIN, sat=0, integrators=0, prev_error=0, pending clear=0, FSM=IDLE.
- Snapshot: start sampled high in IDLE at edge t. target, measured, kp, ki, kd are latched at that edge. busy=1 from t+1. Later input changes have no effect on the frame.
- FSM: IDLE -> ERR -> P -> I -> D -> SUM, then to ERR (next channel) or DONE (after the last channel), then IDLE.
- Each channel takes exactly 5 cycles. done pulses exactly 5*CH+1 cycles after the start edge (21 for CH=4), with busy=0 in the same cycle.
- All pid_out and sat slices update together in the DONE cycle from a shadow register; they hold between frames.
- ERR: e = sext(target) - sext(measured), DW+1 bits, no overflow possible.
- Anti-windup: i_new = clamp(integ + e, -I_LIM, I_LIM). The integrator is held, not updated, if sat[c]=1 from the previous frame and the sign of e would drive further into the same limit: previous output at OUT_MAX and e>0, or at OUT_MIN and e<0.
- P: p = kp*e. I: i = ki*i_new. D: d = kd*(e - prev_error[c]), with the difference DW+2 bits. Gains are treated as non-negative.
- SUM: s = (p+i+d) >>> FRAC. The accumulator is wide enough (IW+GW+2) that it never overflows.
- Output clamp: out = clamp(s, OUT_MIN, OUT_MAX). sat[c] = (s<OUT_MIN) or (s>OUT_MAX). Negative s clamps to OUT_MIN.
- prev_error[c] <= e at SUM. The first frame after reset or clear uses prev_error=0, so a derivative kick is expected behaviour.
- start while busy: ignored, not queued.
- clear_int: in IDLE it applies at that edge. If it arrives with start in the same cycle, the clear happens first and the frame computes from zero state. If it arrives while busy, it is latched as pending and applied on the DONE→IDLE edge; the current frame completes unchanged.
- Reset mid-frame: immediate return to the reset values; no done pulse.

Decomposition:
- pid_pkg holds the state enum typedef (IDLE, ERR, P, I, D, SUM, DONE) and constant width functions for the error, difference and accumulator widths.
- One sub-module, pid_clamp: signed saturating clamp with parameters width/min/max, returning value and flag. It is instantiated for both the integrator clamp and the output clamp.
- The multiplier is a single inferred signed product with operands muxed by state; it is not a separate module.

Test Plan:
- Default params; kp=256, ki=kd=0; ch0 target=1000, measured=600, other channels target=measured=0 -> done 21 cycles after start; out0=400, sat0=0; out1..3=256, sat1..3=1.
- OUT_MIN=0 override; kp=kd=0, ki=128; ch0 error=100 for 3 frames -> out0 = 50, 100, 150.
- OUT_MIN=0, OUT_MAX=800, I_LIM=1000, ki=256; ch0 error=600 for 3 frames -> internal integrator 600, 1000, 1000 (held in frame 3); out0 = 600, 800, 800; sat0 = 0, 1, 1.
- kd=256, kp=ki=0, OUT_MIN=0; ch0 error 0, 300, 300 across 3 frames -> out0 = 0, 300, 0.
- Pulse start again at cycle 5 of a frame -> ignored, only one done. Pulse clear_int at cycle 5 -> frame result unaffected, next frame starts from zero integrator.
- Assert reset at cycle 10 of a frame -> busy=0, done never pulses, all pid_out=256, sat=0. A new start after reset completes normally.
